// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared constants and types for the MIPS fetch front-end.
//   RESET_PC_DEFAULT - first fetch address after reset
//   WORD_MASK        - clears address bits [1:0]
//   fetch_entry_t    - prefetch FIFO entry {instruction, fetch PC + 4}
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO for the prefetch buffer.
//   clk, reset  - clock, asynchronous active-high reset
//   push_i      - write wdata_i at the tail
//   pop_i       - drop the head entry
//   clear_i     - empty the FIFO (wins over push/pop)
//   rdata_o     - head entry (reads 0 when empty after reset)
//   count_o     - number of valid entries
// The caller never pushes when full nor pops when empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]                 cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch-stage front-end of the pipelined MIPS core.
// Owns the fetch PC, issues in-order pipelined imem requests under a credit
// limit, buffers returned words in a prefetch FIFO and presents
// {instruction, PC+4} to IF/ID. Redirects flush the FIFO and discard the
// responses still owed for requests issued before the redirect.
//   clk, reset                         - clock, asynchronous active-high reset
//   i_Redirect, i_RedirectPC_32        - redirect strobe and target
//   i_Stall                            - IF/ID not accepting
//   o_ImemReq, o_ImemAddr_32, i_ImemGnt - request channel
//   i_ImemValid, i_ImemData_32         - in-order response channel
//   o_Valid, o_Instruction_32, o_PCPlus4_32 - head entry toward IF/ID
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC_32,
  input  logic        i_Stall,
  output logic        o_ImemReq,
  output logic [31:0] o_ImemAddr_32,
  input  logic        i_ImemGnt,
  input  logic        i_ImemValid,
  input  logic [31:0] i_ImemData_32,
  output logic        o_Valid,
  output logic [31:0] o_Instruction_32,
  output logic [31:0] o_PCPlus4_32
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
  logic [CW-1:0] out_q, out_d, dsc_q, dsc_d;
  logic [CW-1:0] cnt;
  logic          have_credit, gnt, pop, push, clear;
  fetch_entry_t  push_entry, head;

  // Credit: every outstanding request, stale or not, reserves a FIFO slot,
  // so a response can never land in a full FIFO.
  assign have_credit = ({1'b0, cnt} + {1'b0, out_q}) < (CW+1)'(FIFO_DEPTH);
  assign o_ImemReq   = ~reset & ~i_Redirect & have_credit;
  assign o_ImemAddr_32 = fpc_q;
  assign gnt         = o_ImemReq & i_ImemGnt;

  assign o_Valid = (cnt != '0) & ~i_Redirect;
  assign pop     = o_Valid & ~i_Stall;

  assign push_entry.instr    = i_ImemData_32;
  assign push_entry.pc_plus4 = rpc_q + 32'd4;

  always_comb begin
    fpc_d = fpc_q;
    rpc_d = rpc_q;
    out_d = out_q + CW'(gnt) - CW'(i_ImemValid);
    dsc_d = dsc_q;
    push  = 1'b0;
    clear = 1'b0;
    if (i_Redirect) begin
      // Everything still in flight belongs to the old path; a response
      // arriving now is dropped and no longer owed.
      clear = 1'b1;
      fpc_d = i_RedirectPC_32 & WORD_MASK;
      rpc_d = i_RedirectPC_32 & WORD_MASK;
      dsc_d = out_q - CW'(i_ImemValid);
    end else begin
      if (gnt) fpc_d = fpc_q + 32'd4;
      if (i_ImemValid) begin
        if (dsc_q != '0) begin
          dsc_d = dsc_q - 1'b1;
        end else begin
          push  = 1'b1;
          rpc_d = rpc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q <= RESET_PC;
      rpc_q <= RESET_PC;
      out_q <= '0;
      dsc_q <= '0;
    end else begin
      fpc_q <= fpc_d;
      rpc_q <= rpc_d;
      out_q <= out_d;
      dsc_q <= dsc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .clear_i (clear),
    .rdata_o (head),
    .count_o (cnt)
  );

  assign o_Instruction_32 = head.instr;
  assign o_PCPlus4_32     = head.pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios with
// literal expectations, then randomized stall/grant/redirect/latency traffic
// checked every cycle against a queue-based model of the fetch unit.
module tb_instruction_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_Redirect, i_Stall, i_ImemGnt, i_ImemValid;
  logic [31:0] i_RedirectPC_32, i_ImemData_32;
  logic        o_ImemReq, o_Valid;
  logic [31:0] o_ImemAddr_32, o_Instruction_32, o_PCPlus4_32;

  instruction_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_Redirect(i_Redirect), .i_RedirectPC_32(i_RedirectPC_32),
    .i_Stall(i_Stall),
    .o_ImemReq(o_ImemReq), .o_ImemAddr_32(o_ImemAddr_32), .i_ImemGnt(i_ImemGnt),
    .i_ImemValid(i_ImemValid), .i_ImemData_32(i_ImemData_32),
    .o_Valid(o_Valid), .o_Instruction_32(o_Instruction_32), .o_PCPlus4_32(o_PCPlus4_32)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // environment: in-order memory with per-request due cycle
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  // model: outstanding requests (stale after a redirect) and buffered entries
  typedef struct { logic [31:0] addr; bit stale; } oreq_t;
  oreq_t oq[$];
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  ent_t fq[$];
  logic [31:0] m_fpc;

  int          cyc, lat;
  logic        d_redirect, d_stall, d_gnt;
  logic [31:0] d_target;
  bit          dut_fire;

  function automatic logic [31:0] memword(logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); oq.delete(); fq.delete();
    m_fpc = RPC;
    cyc   = 0;
  endtask

  // One clock cycle: drive at negedge, compare, then advance env + model.
  task automatic step();
    bit          mv, req_m, v_m;
    logic [31:0] md;
    mreq_t       mr;
    oreq_t       o;
    ent_t        e;
    @(negedge clk);
    mv = (mq.size() != 0) && (mq[0].due <= cyc);
    md = mv ? memword(mq[0].addr) : $urandom();
    i_Redirect = d_redirect; i_RedirectPC_32 = d_target; i_Stall = d_stall;
    i_ImemGnt = d_gnt; i_ImemValid = mv; i_ImemData_32 = md;
    #1;
    req_m = !d_redirect && (fq.size() + oq.size() < DEPTH);
    v_m   = !d_redirect && (fq.size() != 0);
    check("req", o_ImemReq, req_m);
    if (req_m) check("addr", o_ImemAddr_32, m_fpc);
    check("valid", o_Valid, v_m);
    if (v_m) begin
      check("instr", o_Instruction_32, fq[0].instr);
      check("pc4", o_PCPlus4_32, fq[0].pc4);
    end
    // memory reacts to the handshake the DUT actually performed
    dut_fire = o_ImemReq && d_gnt;
    if (mv) mr = mq.pop_front();
    if (dut_fire) mq.push_back('{addr: o_ImemAddr_32, due: cyc + lat});
    // model
    if (d_redirect) begin
      if (mv && oq.size() != 0) o = oq.pop_front();
      fq.delete();
      foreach (oq[i]) oq[i].stale = 1'b1;
      m_fpc = d_target & 32'hFFFF_FFFC;
    end else begin
      if (v_m && !d_stall) e = fq.pop_front();
      if (mv && oq.size() != 0) begin
        o = oq.pop_front();
        if (!o.stale) fq.push_back('{instr: memword(o.addr), pc4: o.addr + 32'd4});
      end
      if (req_m && d_gnt) begin
        oq.push_back('{addr: m_fpc, stale: 1'b0});
        m_fpc = m_fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  // release reset so that the next step() is the first cycle out of reset
  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int  nfire;
    bit  found;
    reset = 1'b1;
    i_Redirect = 0; i_RedirectPC_32 = 0; i_Stall = 0; i_ImemGnt = 0;
    i_ImemValid = 0; i_ImemData_32 = 0;
    d_redirect = 0; d_target = 0; d_stall = 0; d_gnt = 1; lat = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", o_ImemReq, 0);
    check("rst_valid", o_Valid, 0);
    check("rst_instr", o_Instruction_32, 0);
    check("rst_pc4", o_PCPlus4_32, 0);

    // free run with single-cycle memory
    release_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) check("first_addr", o_ImemAddr_32, 32'h0040_0000);
      if (k == 2) begin
        check("lit_v2", o_Valid, 1);
        check("lit_i2", o_Instruction_32, 32'h0010_0000);
        check("lit_p2", o_PCPlus4_32, 32'h0040_0004);
      end
      if (k == 3) begin
        check("lit_i3", o_Instruction_32, 32'h0010_0001);
        check("lit_p3", o_PCPlus4_32, 32'h0040_0008);
      end
    end

    // fill the FIFO, then async reset in the middle of a cycle
    d_stall = 1;
    repeat (6) step();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("arst_req", o_ImemReq, 0);
    check("arst_valid", o_Valid, 0);
    check("arst_instr", o_Instruction_32, 0);
    check("arst_pc4", o_PCPlus4_32, 0);

    // stall from the first cycle: exactly DEPTH requests, then stop
    release_reset();
    nfire = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (dut_fire) nfire++;
    end
    check("stall_nreq", nfire, 4);
    check("stall_req_off", o_ImemReq, 0);
    d_stall = 0;
    step();
    check("drain_v", o_Valid, 1);
    check("drain_i", o_Instruction_32, 32'h0010_0000);
    check("drain_p", o_PCPlus4_32, 32'h0040_0004);
    repeat (10) step();

    // 3-cycle memory, redirect with responses still in flight
    lat = 3;
    repeat (8) step();
    d_redirect = 1; d_target = 32'h0040_0100;
    step();
    d_redirect = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (o_Valid) begin
        found = 1;
        check("redir_p", o_PCPlus4_32, 32'h0040_0104);
        check("redir_i", o_Instruction_32, 32'h0010_0040);
      end
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL redir_timeout: got no o_Valid, required one within 40 cycles");
    end

    // redirect coinciding with a response and a pop
    lat = 1;
    repeat (6) step();
    d_redirect = 1; d_target = 32'h0040_0200;
    step();
    check("rv_valid", o_Valid, 0);
    d_redirect = 0;
    step();
    check("rv_addr", o_ImemAddr_32, 32'h0040_0200);
    step();
    step();
    check("rv_v3", o_Valid, 1);
    check("rv_p3", o_PCPlus4_32, 32'h0040_0204);

    // redirect to the top of memory (low bits ignored), grant withheld
    d_redirect = 1; d_target = 32'hFFFF_FFFF; d_gnt = 0;
    step();
    d_redirect = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_req", o_ImemReq, 1);
      check("hold_addr", o_ImemAddr_32, 32'hFFFF_FFFC);
    end
    d_gnt = 1;
    step();
    check("wrap_a0", o_ImemAddr_32, 32'hFFFF_FFFC);
    step();
    check("wrap_a1", o_ImemAddr_32, 32'h0000_0000);
    repeat (6) step();

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if (k % 50 == 0) lat = $urandom_range(4, 1);
      d_stall    = ($urandom_range(99, 0) < 30);
      d_gnt      = ($urandom_range(99, 0) < 70);
      d_redirect = ($urandom_range(99, 0) < 5);
      d_target   = $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
